// File: rtl/snake_tick_ctrl.sv
// rtl/snake_tick_ctrl.sv - snake game move-tick, direction and game-state controller
// Optional pause feature: define SNAKE_PAUSE_EN.
module snake_tick_ctrl #(
    parameter int unsigned BASE_PERIOD = 5000000,
    parameter int unsigned PERIOD_STEP = 250000,
    parameter int unsigned LEN_SHIFT   = 2,
    parameter int unsigned MAX_LEVEL   = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       start,
    input  logic       game_over,
    input  logic [7:0] snake_len,
    output logic       move_tick,
    output logic [1:0] dir,
    output logic [1:0] state,
    output logic       logic_reset
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_OVER  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    localparam logic [23:0] BASE_P = 24'(BASE_PERIOD);
    localparam logic [23:0] STEP_P = 24'(PERIOD_STEP);
    localparam logic [7:0]  MAX_L  = 8'(MAX_LEVEL);

    state_t      r_state;
    logic [23:0] r_cnt;
    logic [23:0] r_period;
    logic        r_tick;
    logic [1:0]  r_dir;
    logic [1:0]  r_pend;
    logic        r_start_q, r_up_q, r_down_q, r_left_q, r_right_q;

    state_t      w_state_nxt;
    logic [23:0] w_cnt_nxt;
    logic [23:0] w_period_nxt;
    logic        w_tick_nxt;
    logic [1:0]  w_dir_nxt;
    logic [1:0]  w_pend_nxt;

    logic        w_start_edge, w_up_edge, w_down_edge, w_left_edge, w_right_edge;
    logic [7:0]  w_level;
    logic [7:0]  w_level_cap;
    logic [23:0] w_period;
    logic        w_dir_req;
    logic [1:0]  w_dir_win;
    logic        w_reverse;

    assign w_start_edge = start & ~r_start_q;
    assign w_up_edge    = up    & ~r_up_q;
    assign w_down_edge  = down  & ~r_down_q;
    assign w_left_edge  = left  & ~r_left_q;
    assign w_right_edge = right & ~r_right_q;

    assign w_level     = snake_len >> LEN_SHIFT;
    assign w_level_cap = (w_level > MAX_L) ? MAX_L : w_level;
    assign w_period    = BASE_P - ({16'd0, w_level_cap} * STEP_P);

    always_comb begin
        w_dir_req = 1'b1;
        w_dir_win = 2'b11;
        if (w_up_edge)         w_dir_win = 2'b00;
        else if (w_down_edge)  w_dir_win = 2'b01;
        else if (w_left_edge)  w_dir_win = 2'b10;
        else if (w_right_edge) w_dir_win = 2'b11;
        else                   w_dir_req = 1'b0;
    end

    // Opposite directions differ only in the low bit (00/01, 10/11).
    assign w_reverse = ((w_dir_win ^ r_dir) == 2'b01);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_tick_nxt   = 1'b0;
        w_dir_nxt    = r_dir;
        w_pend_nxt   = r_pend;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 24'd0;
                if (w_start_edge) begin
                    w_state_nxt  = ST_RUN;
                    w_dir_nxt    = 2'b11;
                    w_pend_nxt   = 2'b11;
                    w_period_nxt = w_period;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    w_state_nxt = ST_OVER;
                end
`ifdef SNAKE_PAUSE_EN
                else if (w_start_edge) begin
                    w_state_nxt = ST_PAUSE;
                end
`endif
                else begin
                    if (r_cnt == r_period - 24'd1) begin
                        w_cnt_nxt    = 24'd0;
                        w_tick_nxt   = 1'b1;
                        w_dir_nxt    = r_pend;
                        w_period_nxt = w_period;
                    end else begin
                        w_cnt_nxt = r_cnt + 24'd1;
                    end
                    if (w_dir_req && !w_reverse) begin
                        w_pend_nxt = w_dir_win;
                    end
                end
            end
            ST_OVER: begin
                w_cnt_nxt = 24'd0;
                if (w_start_edge) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PAUSE: begin
`ifdef SNAKE_PAUSE_EN
                if (w_start_edge) begin
                    w_state_nxt = ST_RUN;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 24'd0;
            r_period  <= 24'd0;
            r_tick    <= 1'b0;
            r_dir     <= 2'b11;
            r_pend    <= 2'b11;
            r_start_q <= 1'b0;
            r_up_q    <= 1'b0;
            r_down_q  <= 1'b0;
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_period  <= w_period_nxt;
            r_tick    <= w_tick_nxt;
            r_dir     <= w_dir_nxt;
            r_pend    <= w_pend_nxt;
            r_start_q <= start;
            r_up_q    <= up;
            r_down_q  <= down;
            r_left_q  <= left;
            r_right_q <= right;
        end
    end

    assign move_tick   = r_tick;
    assign dir         = r_dir;
    assign state       = r_state;
    assign logic_reset = (r_state == ST_IDLE);

endmodule

// File: tb/tb_snake_tick_ctrl.sv
// tb/tb_snake_tick_ctrl.sv - self-checking bench for snake_tick_ctrl against a countdown model
module tb_snake_tick_ctrl;

`ifdef SNAKE_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       start = 1'b0, game_over = 1'b0;
    logic [7:0] snake_len = 8'd3;
    logic       move_tick;
    logic [1:0] dir;
    logic [1:0] state;
    logic       logic_reset;

    int checks = 0;
    int failures = 0;

    // model: 0 idle, 1 run, 2 over, 3 pause; m_rem = cycles left until the next tick
    int m_st = 0, m_dir = 3, m_pend = 3, m_rem = 0;
    bit m_tick = 1'b0;
    bit p_up, p_down, p_left, p_right, p_start;

    snake_tick_ctrl #(
        .BASE_PERIOD(20),
        .PERIOD_STEP(2),
        .LEN_SHIFT  (2),
        .MAX_LEVEL  (4)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .start      (start),
        .game_over  (game_over),
        .snake_len  (snake_len),
        .move_tick  (move_tick),
        .dir        (dir),
        .state      (state),
        .logic_reset(logic_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int period_of(input logic [7:0] len);
        int lvl;
        lvl = int'(len) / 4;
        if (lvl > 4) lvl = 4;
        return 20 - 2 * lvl;
    endfunction

    function automatic int opp(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_cycle();
        bit eu, ed, el, er, es;
        int w, od;
        if (rst) begin
            m_st = 0; m_dir = 3; m_pend = 3; m_rem = 0; m_tick = 1'b0;
            p_up = 0; p_down = 0; p_left = 0; p_right = 0; p_start = 0;
            return;
        end
        eu = up && !p_up;       ed = down && !p_down;
        el = left && !p_left;   er = right && !p_right;
        es = start && !p_start;
        m_tick = 1'b0;
        od = m_dir;
        case (m_st)
            0: if (es) begin m_st = 1; m_dir = 3; m_pend = 3; m_rem = period_of(snake_len); end
            1: begin
                if (game_over) m_st = 2;
                else if (es && PAUSE_EN) m_st = 3;
                else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_tick = 1'b1;
                        m_dir = m_pend;
                        m_rem = period_of(snake_len);
                    end
                    w = -1;
                    if (eu) w = 0; else if (ed) w = 1; else if (el) w = 2; else if (er) w = 3;
                    if (w >= 0 && w != opp(od)) m_pend = w;
                end
            end
            2: if (es) m_st = 0;
            default: if (es) m_st = 1;
        endcase
        p_up = up; p_down = down; p_left = left; p_right = right; p_start = start;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        chk("cyc_tick", 32'(move_tick), 32'(m_tick));
        chk("cyc_dir", 32'(dir), 32'(m_dir));
        chk("cyc_state", 32'(state), 32'(m_st));
        chk("cyc_lreset", 32'(logic_reset), (m_st == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_to_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = move_tick;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int first, last, nt;
        step(); step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lreset", 32'(logic_reset), 32'd1);
        chk("rst_dir", 32'(dir), 32'd3);
        chk("rst_tick", 32'(move_tick), 32'd0);
        rst = 1'b0;
        step();

        start = 1'b1; step(); start = 1'b0;
        chk("run_entry", 32'(state), 32'd1);
        chk("run_dir", 32'(dir), 32'd3);
        first = -1; nt = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (move_tick) begin nt++; if (first < 0) first = i; end
        end
        chk("first_tick", 32'(first), 32'd20);
        chk("ticks_40", 32'(nt), 32'd2);

        for (int i = 0; i < 5; i++) step();
        snake_len = 8'd20;
        first = -1; last = 0; nt = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (move_tick) begin nt++; last = i; if (first < 0) first = i; end
        end
        chk("len_first", 32'(first), 32'd15);
        chk("len_ticks", 32'(nt), 32'd3);
        chk("len_last", 32'(last), 32'd39);

        left = 1'b1; step(); left = 1'b0;
        run_to_tick("tick_left");
        chk("left_ignored", 32'(dir), 32'd3);
        up = 1'b1; step(); up = 1'b0; step();
        down = 1'b1; step(); down = 1'b0;
        run_to_tick("tick_ud");
        chk("up_then_down", 32'(dir), 32'd1);
        right = 1'b1; step(); right = 1'b0;
        run_to_tick("tick_r");
        chk("right", 32'(dir), 32'd3);
        up = 1'b1; left = 1'b1; step(); up = 1'b0; left = 1'b0;
        run_to_tick("tick_ul");
        chk("up_left", 32'(dir), 32'd0);
        down = 1'b1; left = 1'b1; step(); down = 1'b0; left = 1'b0;
        run_to_tick("tick_dl");
        chk("winner_rev", 32'(dir), 32'd0);

        for (int i = 0; i < 40 && m_rem != 1; i++) step();
        chk("go_align", 32'(m_rem), 32'd1);
        game_over = 1'b1; step(); game_over = 1'b0;
        chk("go_state", 32'(state), 32'd2);
        chk("go_notick", 32'(move_tick), 32'd0);
        chk("go_dir", 32'(dir), 32'd0);
        step(); step();
        start = 1'b1; step();
        chk("over_idle", 32'(state), 32'd0);
        chk("over_lreset", 32'(logic_reset), 32'd1);
        step();
        chk("start_held", 32'(state), 32'd0);
        start = 1'b0; step();

        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        #3 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_tick", 32'(move_tick), 32'd0);
        chk("arst_dir", 32'(dir), 32'd3);
        chk("arst_lreset", 32'(logic_reset), 32'd1);
        step();
        rst = 1'b0;
        nt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (move_tick) nt++;
        end
        chk("no_tick_after_rst", 32'(nt), 32'd0);

        snake_len = 8'd3;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        start = 1'b1; step(); start = 1'b0;
        chk("start_in_run", 32'(state), PAUSE_EN ? 32'd3 : 32'd1);
        for (int i = 0; i < 30; i++) step();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20; i++) step();

        for (int i = 0; i < 600; i++) begin
            up        = ($urandom_range(0, 7) == 0);
            down      = ($urandom_range(0, 7) == 0);
            left      = ($urandom_range(0, 7) == 0);
            right     = ($urandom_range(0, 7) == 0);
            start     = ($urandom_range(0, 40) == 0);
            game_over = ($urandom_range(0, 80) == 0);
            if ($urandom_range(0, 30) == 0) snake_len = 8'($urandom_range(0, 255));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snake_tick_ctrl.md
SNAKE_TICK_CTRL -- requirements
Module: snake_tick_ctrl

Interface
REQ-001 Parameter BASE_PERIOD, default 5000000, is the move period in clk cycles at level 0 (10 Hz at 50 MHz).
REQ-002 Parameter PERIOD_STEP, default 250000, is the number of cycles removed from the period per level.
REQ-003 Parameter LEN_SHIFT, default 2, sets level as snake_len >> LEN_SHIFT.
REQ-004 Parameter MAX_LEVEL, default 12, is the cap on level; BASE_PERIOD > MAX_LEVEL*PERIOD_STEP SHALL hold.
REQ-005 Port: clk  input  1  system clock, 50 MHz.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Ports: up, down, left, right  input  1 each  level button inputs, already synchronised.
REQ-008 Port: start  input  1  level start/pause button.
REQ-009 Port: game_over  input  1  collision flag from the game logic.
REQ-010 Port: snake_len  input  8  current snake length.
REQ-011 Port: move_tick  output  1  one-cycle pulse that advances the snake by one cell.
REQ-012 Port: dir  output  2  committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-013 Port: state  output  2  FSM state: 00 IDLE, 01 RUN, 10 OVER, 11 PAUSE.
REQ-014 Port: logic_reset  output  1  reset drive to the game logic.

Function
REQ-015 Rising edges SHALL be detected on start, up, down, left and right using registered previous values; a level held high SHALL NOT retrigger.
REQ-016 IDLE: logic_reset=1, move_tick=0, and the counter is held at 0.
  - A start edge SHALL move to RUN, set dir=11 and set the pending direction to 11.
REQ-017 RUN: logic_reset=0 and the 24-bit counter increments every cycle.
  - When the counter equals period-1, the counter SHALL wrap to 0 and move_tick SHALL be 1 in the next cycle.
  - The first tick SHALL occur exactly period cycles after entering RUN.
REQ-018 Period SHALL be computed as BASE_PERIOD - min(snake_len>>LEN_SHIFT, MAX_LEVEL)*PERIOD_STEP.
  - The period SHALL be sampled only at counter wrap, so a change in snake_len affects the following interval.
REQ-019 A direction edge in RUN SHALL load the pending direction unless it is the reverse of the committed dir.
  - Reverse pairs are up/down and left/right; a reverse request SHALL be ignored.
  - A later accepted edge before the next tick SHALL overwrite the pending direction.
REQ-020 Simultaneous direction edges SHALL resolve with priority up > down > left > right, and the reversal check SHALL apply to the winner only.
REQ-021 dir SHALL take the pending value in the same cycle that move_tick is 1, giving at most one turn per tick.
REQ-022 game_over=1 in RUN SHALL move to OVER on the next edge.
  - If game_over coincides with a tick condition, game_over wins and no tick is emitted.
REQ-023 OVER: move_tick=0, dir is held and logic_reset=0, which preserves the final board.
  - A start edge SHALL move to IDLE.
REQ-024 Direction edges outside RUN SHALL be ignored.

Reset
REQ-025 Asserting reset SHALL immediately force, regardless of clk: state=IDLE, counter=0, move_tick=0, dir=11, pending=11, logic_reset=1, and all edge-detect registers=0.
REQ-026 Reset asserted mid-RUN SHALL abort the interval, and no tick SHALL appear after release until a new start edge.

Configuration
REQ-027 Macro SNAKE_PAUSE_EN, when defined, SHALL enable pausing.
  - A start edge in RUN SHALL go to PAUSE, and a start edge in PAUSE SHALL return to RUN.
  - In PAUSE the counter and pending direction are held, move_tick=0, and game_over is ignored.
REQ-028 Without SNAKE_PAUSE_EN, start edges in RUN SHALL be ignored and state 11 SHALL be unreachable.

Verification
Bench parameters: BASE_PERIOD=20, PERIOD_STEP=2, LEN_SHIFT=2, MAX_LEVEL=4.
REQ-029 Reset, start pulse, snake_len=3 -> RUN, dir=11, move_tick pulses every 20 cycles, first pulse 20 cycles after RUN entry.
REQ-030 snake_len=20 mid-interval -> current interval stays 20; subsequent intervals are 12 (level capped at 4).
REQ-031 dir=11, press left -> ignored, dir stays 11; press up then down within one interval -> at next tick dir=01 (down); up+left same cycle -> dir=00.
REQ-032 game_over=1 on the same cycle the counter reaches 19 -> no tick, state=OVER, dir held; start edge -> IDLE, logic_reset=1.
REQ-033 Reset asserted asynchronously mid-RUN at counter=7 -> outputs at reset values within the same cycle; no ticks for 100 cycles after release without start.
REQ-034 With SNAKE_PAUSE_EN: start at counter=5 -> PAUSE for 30 cycles with no tick; start again -> next tick 15 cycles after resuming. Without SNAKE_PAUSE_EN -> the start edge is ignored.
